// File: rtl/divu_hilo.sv
// Sequential 32-iteration restoring unsigned divider that owns the HI/LO result registers.
// Remainder lands in HiOut, quotient in LoOut; both change only when a division completes.
module divu_hilo #(
  parameter int         WIDTH = 32,
  parameter logic [5:0] DIVU  = 6'b011011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
  output logic             done
);

  localparam int           CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_next;
  logic             w_start;

  // The partial remainder is always below the divisor, so its top bit is never stored.
  always_comb begin
    w_shift     = {r_rem, r_quot[WIDTH-1]};
    w_trial     = w_shift - {1'b0, r_divisor};
    w_start     = (Signal == DIVU);
    if (w_trial[WIDTH] == 1'b0) begin
      w_rem_next  = w_trial[WIDTH-1:0];
      w_quot_next = {r_quot[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_next  = w_shift[WIDTH-1:0];
      w_quot_next = {r_quot[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_divisor <= {WIDTH{1'b0}};
      r_quot    <= {WIDTH{1'b0}};
      r_rem     <= {WIDTH{1'b0}};
      r_count   <= C_ZERO;
      HiOut     <= {WIDTH{1'b0}};
      LoOut     <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_divisor <= dataB;
            r_quot    <= dataA;
            r_rem     <= {WIDTH{1'b0}};
            r_count   <= C_ZERO;
            busy      <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_rem   <= w_rem_next;
          r_quot  <= w_quot_next;
          r_count <= r_count + C_ONE;
          // Results are published only once the final iteration resolves.
          if (r_count == C_LAST) begin
            HiOut   <= w_rem_next;
            LoOut   <= w_quot_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_hilo.sv
// Self-checking bench for divu_hilo: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_divu_hilo;

  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] NOP  = 6'b100000;
  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MFLO = 6'b010010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataA = 32'd0;
  logic [31:0] dataB = 32'd0;
  logic [5:0]  Signal = NOP;
  logic [31:0] HiOut, LoOut;
  logic        busy, done;

  int n_vec = 0;
  int n_err = 0;

  divu_hilo #(.WIDTH(32), .DIVU(DIVU)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .HiOut(HiOut), .LoOut(LoOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a division takes 32 cycles after acceptance, result from / and %.
  logic [31:0] m_a, m_b, m_hi, m_lo;
  logic        m_busy, m_done;
  int          m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a <= 32'd0; m_b <= 32'd0; m_hi <= 32'd0; m_lo <= 32'd0;
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (Signal == DIVU) begin
          m_busy <= 1'b1; m_left <= 32; m_a <= dataA; m_b <= dataB;
        end
      end else begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= (m_b == 32'd0) ? m_a : (m_a % m_b);
          m_lo   <= (m_b == 32'd0) ? 32'hFFFFFFFF : (m_a / m_b);
        end
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_hi", HiOut, m_hi);
    chk("model_lo", LoOut, m_lo);
    chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
    chk("model_done", {31'd0, done}, {31'd0, m_done});
  end

  // Drive a start for one cycle; returns at the negedge right after the start edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Signal = DIVU; dataA = a; dataB = b;
    @(negedge clk);
    Signal = NOP; dataA = 32'hDEADBEEF; dataB = 32'h0BADF00D;
  endtask

  task automatic wait_done(input string name, output int cycles);
    bit got = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_timeout"}, {31'd0, got}, 32'd1);
  endtask

  initial begin
    int cyc;
    int ndone;
    logic [31:0] hold_hi, hold_lo;

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hi", HiOut, 32'd0);
    chk("rst_lo", LoOut, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // 100 / 7 with exact latency: done appears on the 33rd edge counting the start edge.
    start(32'd100, 32'd7);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      chk("lat_early_done", {31'd0, done}, 32'd0);
      chk("lat_hold_lo", LoOut, 32'd0);
    end
    @(negedge clk);
    chk("lat_done", {31'd0, done}, 32'd1);
    chk("lat_busy_low", {31'd0, busy}, 32'd0);
    chk("d100_7_lo", LoOut, 32'd14);
    chk("d100_7_hi", HiOut, 32'd2);
    @(negedge clk);
    chk("lat_done_pulse", {31'd0, done}, 32'd0);

    start(32'd5, 32'd9);
    wait_done("d5_9", cyc);
    chk("d5_9_lo", LoOut, 32'd0);
    chk("d5_9_hi", HiOut, 32'd5);

    start(32'hFFFFFFFF, 32'd1);
    wait_done("dmax_1", cyc);
    chk("dmax_1_lo", LoOut, 32'hFFFFFFFF);
    chk("dmax_1_hi", HiOut, 32'd0);

    start(32'h12345678, 32'd0);
    wait_done("dzero", cyc);
    chk("dzero_lo", LoOut, 32'hFFFFFFFF);
    chk("dzero_hi", HiOut, 32'h12345678);

    // DIVU while busy is ignored; operands change freely after the start edge.
    start(32'd1000, 32'd10);
    repeat (4) @(negedge clk);
    Signal = DIVU; dataA = 32'd7; dataB = 32'd2;
    @(negedge clk);
    Signal = NOP; dataA = 32'd123; dataB = 32'd4;
    wait_done("d1000_10", cyc);
    chk("d1000_10_cycle", cyc, 32'd27);
    chk("d1000_10_lo", LoOut, 32'd100);
    chk("d1000_10_hi", HiOut, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_second_done", ndone, 32'd0);

    // Back-to-back: start accepted on the edge where done falls.
    @(negedge clk);
    Signal = DIVU; dataA = 32'd9; dataB = 32'd4;
    wait_done("b2b_first", cyc);
    chk("b2b_first_lo", LoOut, 32'd2);
    chk("b2b_first_hi", HiOut, 32'd1);
    dataA = 32'd20; dataB = 32'd6;
    @(negedge clk);
    Signal = NOP;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b_second", cyc);
    chk("b2b_second_cycle", cyc, 32'd32);
    chk("b2b_second_lo", LoOut, 32'd3);
    chk("b2b_second_hi", HiOut, 32'd2);

    start(32'd50, 32'd8);
    wait_done("d50_8", cyc);
    chk("d50_8_lo", LoOut, 32'd6);
    chk("d50_8_hi", HiOut, 32'd2);

    // Reset mid-run clears outputs asynchronously.
    start(32'd77, 32'd3);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_hi", HiOut, 32'd0);
    chk("arst_lo", LoOut, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst_no_done", ndone, 32'd0);
    chk("arst_hold_lo", LoOut, 32'd0);

    start(32'd77, 32'd3);
    wait_done("d77_3", cyc);
    chk("d77_3_lo", LoOut, 32'd25);
    chk("d77_3_hi", HiOut, 32'd2);

    // MFHI / MFLO never disturb the result registers.
    hold_hi = 32'd2;
    hold_lo = 32'd25;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      Signal = (i < 20) ? MFHI : MFLO;
      chk("mf_hi", HiOut, hold_hi);
      chk("mf_lo", LoOut, hold_lo);
      chk("mf_busy", {31'd0, busy}, 32'd0);
    end
    Signal = NOP;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
